// File: rtl/consmax_mc.sv
// consmax_mc: per-lane split-index LUT product with right shift and saturation.
// Each lane splits its input into two table indices and multiplies one HI entry
// by one LO entry. The product is shifted right and clamped to the output width.
// The data path is a three-stage elastic pipeline with valid/ready handshakes.
module consmax_mc #(
    parameter int NCH       = 4,
    parameter int IDATA_BIT = 8,
    parameter int ODATA_BIT = 8,
    parameter int LUT_DATA  = 16,
    parameter int SHIFT_BIT = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SHIFT_BIT-1:0]          cfg_shift,
    input  logic                          lut_wen,
    input  logic [IDATA_BIT/2:0]          lut_waddr,
    input  logic [LUT_DATA-1:0]           lut_wdata,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NCH*IDATA_BIT-1:0]      idata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NCH*ODATA_BIT-1:0]      odata,
    output logic [NCH-1:0]                sat_flag,
    output logic                          busy
);

    localparam int LUT_ADDR  = IDATA_BIT / 2;
    localparam int LUT_DEPTH = 1 << LUT_ADDR;
    localparam int PROD_BIT  = 2 * LUT_DATA;

    logic [LUT_DATA-1:0]  hi_lut [LUT_DEPTH];
    logic [LUT_DATA-1:0]  lo_lut [LUT_DEPTH];
    logic [LUT_DATA-1:0]  hi_rd  [NCH];
    logic [LUT_DATA-1:0]  lo_rd  [NCH];

    logic                 s1_valid;
    logic [LUT_DATA-1:0]  s1_hi  [NCH];
    logic [LUT_DATA-1:0]  s1_lo  [NCH];
    logic [SHIFT_BIT-1:0] s1_shift;

    logic                 s2_valid;
    logic [PROD_BIT-1:0]  s2_prod [NCH];
    logic [SHIFT_BIT-1:0] s2_shift;

    logic                 s3_valid;
    logic [PROD_BIT-1:0]  res [NCH];

    logic adv1, adv2, adv3;

    // Stage advance chain: a stage moves when empty or when its consumer moves
    always_comb begin
        adv3     = !s3_valid || out_ready;
        adv2     = !s2_valid || adv3;
        adv1     = !s1_valid || adv2;
        in_ready = adv1;
        busy     = s1_valid | s2_valid | s3_valid;
    end

    // Shared tables, one combinational read port per lane on each table
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            hi_rd[k] = hi_lut[idata[k*IDATA_BIT+LUT_ADDR +: LUT_ADDR]];
            lo_rd[k] = lo_lut[idata[k*IDATA_BIT +: LUT_ADDR]];
        end
    end

    // Table writes land at the edge; reset clears every entry and wins over a write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
                hi_lut[i] <= '0;
                lo_lut[i] <= '0;
            end
        end else if (lut_wen) begin
            if (lut_waddr[LUT_ADDR])
                hi_lut[lut_waddr[LUT_ADDR-1:0]] <= lut_wdata;
            else
                lo_lut[lut_waddr[LUT_ADDR-1:0]] <= lut_wdata;
        end
    end

    // Shift with an explicit zero for amounts that clear the whole product
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            if (int'(s2_shift) >= PROD_BIT)
                res[k] = '0;
            else
                res[k] = s2_prod[k] >> s2_shift;
        end
    end

    // Three-stage pipeline: S1 LUT reads + shift, S2 product, S3 clamped output
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            odata     <= '0;
            sat_flag  <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_shift <= cfg_shift;
                    for (int unsigned k = 0; k < NCH; k++) begin
                        s1_hi[k] <= hi_rd[k];
                        s1_lo[k] <= lo_rd[k];
                    end
                end
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_shift <= s1_shift;
                    for (int unsigned k = 0; k < NCH; k++)
                        s2_prod[k] <= PROD_BIT'(s1_hi[k]) * PROD_BIT'(s1_lo[k]);
                end
            end
            if (adv3) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    for (int unsigned k = 0; k < NCH; k++) begin
                        if (res[k][PROD_BIT-1:ODATA_BIT] != '0) begin
                            odata[k*ODATA_BIT +: ODATA_BIT] <= '1;
                            sat_flag[k]                     <= 1'b1;
                        end else begin
                            odata[k*ODATA_BIT +: ODATA_BIT] <= res[k][ODATA_BIT-1:0];
                            sat_flag[k]                     <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign out_valid = s3_valid;

endmodule
